lif_chain: RTL and testbench

//  Parametrised chain of NUM_NEURONS leaky integrate-and-fire neurons sharing one clock.

---
 rtl/lif_chain_if.sv | 25 ++
 rtl/lif_chain.sv | 141 ++++++++++++++
 tb/tb_lif_chain.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lif_chain_if.sv
// Bus bundle for the LIF chain: control and stimulus toward the core, spikes and readout back.
interface lif_chain_if #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_NEURONS = 2,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SEL_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
);
    logic                   en;
    logic [WIDTH-1:0]       current_in;
    logic [WIDTH-1:0]       thresh;
    logic [SEL_W-1:0]       sel;
    logic [NUM_NEURONS-1:0] spikes;
    logic [WIDTH-1:0]       state_out;
    logic [CNT_WIDTH-1:0]   count_out;

    modport master (
        output en, current_in, thresh, sel,
        input  spikes, state_out, count_out
    );

    modport slave (
        input  en, current_in, thresh, sel,
        output spikes, state_out, count_out
    );
endinterface

// File: rtl/lif_chain.sv
// Chain of leaky integrate-and-fire neurons with a refractory FSM, saturating membranes
// and a selectable membrane readout. Optional per-neuron spike counters are built when
// LIF_SPIKE_COUNT_EN is defined; otherwise count_out is tied to zero.
module lif_chain #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned NUM_NEURONS    = 2,
    parameter int unsigned LEAK_SHIFT     = 1,
    parameter int unsigned REFRACT_CYCLES = 2,
    parameter int unsigned CHAIN_WEIGHT   = 200,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic       clk,
    input  logic       rst,
    lif_chain_if.slave bus
);
    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned RC_W  = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    localparam logic [0:0] ST_INTEG  = 1'b0;
    localparam logic [0:0] ST_REFRAC = 1'b1;

    logic [WIDTH-1:0]       v_q    [NUM_NEURONS];
    logic [WIDTH-1:0]       v_d    [NUM_NEURONS];
    logic [0:0]             st_q   [NUM_NEURONS];
    logic [0:0]             st_d   [NUM_NEURONS];
    logic [RC_W-1:0]        rcnt_q [NUM_NEURONS];
    logic [RC_W-1:0]        rcnt_d [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spk_q;
    logic [NUM_NEURONS-1:0] spk_d;

    logic [WIDTH-1:0]       cur    [NUM_NEURONS];
    logic [SUM_W-1:0]       sum    [NUM_NEURONS];
    logic [WIDTH-1:0]       v_sat  [NUM_NEURONS];
    logic [WIDTH-1:0]       state_mux;

    // Per-neuron input current, leaked membrane plus current, clamped at full scale
    always_comb begin
        cur[0] = bus.current_in;
        for (int i = 1; i < NUM_NEURONS; i++) begin
            cur[i] = spk_q[i-1] ? WIDTH'(CHAIN_WEIGHT) : '0;
        end
        for (int i = 0; i < NUM_NEURONS; i++) begin
            sum[i]   = SUM_W'(v_q[i] >> LEAK_SHIFT) + SUM_W'(cur[i]);
            v_sat[i] = sum[i][WIDTH] ? '1 : sum[i][WIDTH-1:0];
        end
    end

    // Next-state logic: integrate/fire and refractory countdown; hold everything when disabled
    always_comb begin
        v_d    = v_q;
        st_d   = st_q;
        rcnt_d = rcnt_q;
        spk_d  = '0;
        if (bus.en) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                case (st_q[i])
                    ST_INTEG: begin
                        if (v_q[i] >= bus.thresh) begin
                            spk_d[i]  = 1'b1;
                            v_d[i]    = '0;
                            rcnt_d[i] = RC_W'(REFRACT_CYCLES);
                            st_d[i]   = (REFRACT_CYCLES == 0) ? ST_INTEG : ST_REFRAC;
                        end else begin
                            v_d[i] = v_sat[i];
                        end
                    end
                    ST_REFRAC: begin
                        v_d[i]    = '0;
                        rcnt_d[i] = rcnt_q[i] - RC_W'(1);
                        if (rcnt_q[i] == RC_W'(1)) begin
                            st_d[i] = ST_INTEG;
                        end
                    end
                    default: begin
                        st_d[i] = ST_INTEG;
                    end
                endcase
            end
        end
    end

    // State registers; reset wins over enable and any FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i]    <= '0;
                st_q[i]   <= ST_INTEG;
                rcnt_q[i] <= '0;
            end
            spk_q <= '0;
        end else begin
            v_q    <= v_d;
            st_q   <= st_d;
            rcnt_q <= rcnt_d;
            spk_q  <= spk_d;
        end
    end

    // Membrane readout of the selected neuron; out-of-range selections read as zero
    always_comb begin
        state_mux = '0;
        if (32'(bus.sel) < NUM_NEURONS) begin
            state_mux = v_q[bus.sel];
        end
    end

    assign bus.spikes    = spk_q;
    assign bus.state_out = state_mux;

`ifdef LIF_SPIKE_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
    logic [CNT_WIDTH-1:0] cnt_mux;

    // Saturating spike counters, stepped on the same edge the spike flag is set
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (spk_d[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Counter readout of the selected neuron
    always_comb begin
        cnt_mux = '0;
        if (32'(bus.sel) < NUM_NEURONS) begin
            cnt_mux = cnt_q[bus.sel];
        end
    end

    assign bus.count_out = cnt_mux;
`else
    assign bus.count_out = '0;
`endif
endmodule

// File: tb/tb_lif_chain.sv
// Directed bench for lif_chain (default parameters, two neurons): a vector table covering
// integration, saturation, threshold zero, reset mid-refractory and enable hold, plus
// hand-written sequences for reset behaviour and the spike counters.
module tb_lif_chain;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    lif_chain_if #(.WIDTH(8), .NUM_NEURONS(2), .CNT_WIDTH(8)) bus ();

    lif_chain #(
        .WIDTH(8), .NUM_NEURONS(2), .LEAK_SHIFT(1),
        .REFRACT_CYCLES(2), .CHAIN_WEIGHT(200), .CNT_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] cur;
        logic [7:0] thr;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [1:0] spk;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

`ifdef LIF_SPIKE_COUNT_EN
    localparam int CNT_ONE = 1;
    localparam int CNT_SAT = 255;
`else
    localparam int CNT_ONE = 0;
    localparam int CNT_SAT = 0;
`endif

    // Neuron 0 at current 60, threshold 100: edges 1..11 after reset release
    localparam int T2V0[11] = '{60, 90, 105, 0, 0, 0, 60, 90, 105, 0, 0};
    localparam int T2V1[11] = '{0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 200};
    localparam int T2S [11] = '{0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 0};

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic e, input int cur, input int thr,
                                input int v0, input int v1, input int spk);
        vec_t x;
        x.rst = r;
        x.en  = e;
        x.cur = 8'(cur);
        x.thr = 8'(thr);
        x.v0  = 8'(v0);
        x.v1  = 8'(v1);
        x.spk = 2'(spk);
        vecs.push_back(x);
    endfunction

    // Reset row driven with inputs that would otherwise fire immediately
    function automatic void add_rst();
        add(1'b1, 1'b1, 255, 0, 0, 0, 0);
    endfunction

    function automatic void add_t2(input int n);
        for (int k = 0; k < n; k++) begin
            add(1'b0, 1'b1, 60, 100, T2V0[k], T2V1[k], T2S[k]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input int idx,
                                 input int v0, input int v1, input int spk);
        check({name, ".spikes"}, idx, int'(bus.spikes), spk);
        bus.sel = 1'b0;
        #1;
        check({name, ".v0"}, idx, int'(bus.state_out), v0);
        bus.sel = 1'b1;
        #1;
        check({name, ".v1"}, idx, int'(bus.state_out), v1);
    endtask

    initial begin
        bus.en         = 1'b1;
        bus.current_in = 8'd255;
        bus.thresh     = 8'd0;
        bus.sel        = 1'b0;

        // Reset held three cycles with firing inputs: everything stays cleared
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outputs("reset_hold", k, 0, 0, 0);
            check("reset_hold.count", k, int'(bus.count_out), 0);
        end

        add_rst();
        add_t2(11);
        // Reset while neuron 0 is refractory and neuron 1 holds 200, then replay
        add_rst();
        add_t2(5);
        add_rst();
        add_t2(6);
        // Saturation: 100 + 200 clamps to 255 instead of wrapping to 44
        add_rst();
        add(1'b0, 1'b1, 200, 255, 200, 0, 0);
        add(1'b0, 1'b1, 200, 255, 255, 0, 0);
        add(1'b0, 1'b1, 200, 255, 0, 0, 1);
        add(1'b0, 1'b1, 200, 255, 0, 200, 0);
        add(1'b0, 1'b1, 200, 255, 0, 100, 0);
        add(1'b0, 1'b1, 200, 255, 200, 50, 0);
        // Full-scale current and threshold
        add_rst();
        add(1'b0, 1'b1, 255, 255, 255, 0, 0);
        add(1'b0, 1'b1, 255, 255, 0, 0, 1);
        add(1'b0, 1'b1, 255, 255, 0, 200, 0);
        add(1'b0, 1'b1, 255, 255, 0, 100, 0);
        add(1'b0, 1'b1, 255, 255, 255, 50, 0);
        add(1'b0, 1'b1, 255, 255, 0, 25, 1);
        // Threshold zero: both neurons fire every third edge
        add_rst();
        for (int k = 0; k < 7; k++) begin
            add(1'b0, 1'b1, 0, 0, 0, 0, (k % 3 == 0) ? 3 : 0);
        end
        // Enable low holds v at 90, then resumes; a held spike's chain injection is lost
        add_rst();
        add(1'b0, 1'b1, 60, 100, 60, 0, 0);
        add(1'b0, 1'b1, 60, 100, 90, 0, 0);
        for (int k = 0; k < 5; k++) begin
            add(1'b0, 1'b0, 60, 100, 90, 0, 0);
        end
        add(1'b0, 1'b1, 60, 100, 105, 0, 0);
        add(1'b0, 1'b1, 60, 100, 0, 0, 1);
        add(1'b0, 1'b0, 60, 100, 0, 0, 0);
        add(1'b0, 1'b1, 60, 100, 0, 0, 0);
        add(1'b0, 1'b1, 60, 100, 0, 0, 0);
        add(1'b0, 1'b1, 60, 100, 60, 0, 0);

        foreach (vecs[i]) begin
            rst            = vecs[i].rst;
            bus.en         = vecs[i].en;
            bus.current_in = vecs[i].cur;
            bus.thresh     = vecs[i].thr;
            tick();
            check_outputs("table", i, int'(vecs[i].v0), int'(vecs[i].v1), int'(vecs[i].spk));
        end

        // Spike counters: one after the first spike, saturated after many
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.en         = 1'b1;
        bus.current_in = 8'd0;
        bus.thresh     = 8'd0;
        bus.sel        = 1'b0;
        tick();
        check("count.first", 0, int'(bus.count_out), CNT_ONE);
        bus.sel = 1'b1;
        #1;
        check("count.first_n1", 0, int'(bus.count_out), CNT_ONE);
        bus.sel = 1'b0;
        for (int k = 0; k < 800; k++) begin
            tick();
        end
        check("count.sat", 0, int'(bus.count_out), CNT_SAT);
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        check("count.sat_hold", 0, int'(bus.count_out), CNT_SAT);
        rst = 1'b1;
        tick();
        check("count.reset", 0, int'(bus.count_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
